// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam int DISP_DATA_W = 32;
  // Shortest hold time; a dwell request of 0 is stretched to this.
  localparam int MIN_DWELL   = 1;

endpackage

// File: rtl/display_scheduler_rr_arbiter.sv
// Round-robin winner search: first set request bit at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is taken.
// Ports: req (request vector), ptr (search start), gnt (one-hot winner),
//        idx (encoded winner), any (at least one request set).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate position ptr+i folded back into 0..N-1 (ptr is always < N).
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 7-segment display word between requesters, round-robin, with a dwell hold.
// Latency: accept in the request cycle (req_ready combinational), disp_din valid the next cycle.
// Backpressure: req_ready stays low during DWELL; requesters hold req_valid until accepted.
// Ports: req_valid/req_data/req_ready (requester side), dwell_cycles (hold time, sampled at grant),
//        cfg_div -> disp_div (registered pass-through), disp_din/grant_idx/busy (display side).
// Option: define DISPLAY_SCHED_PREEMPT_EN to let requester 0 preempt any other holder during DWELL.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DISP_DATA_W,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [CNT_W-1:0]            dwell_cycles,
  input  logic [31:0]                 cfg_div,
  output logic [DATA_W-1:0]           disp_din,
  output logic [31:0]                 disp_div,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  output logic                        busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  dwell_eff;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic              arb_any;
  logic              load;
  logic [IW-1:0]     load_idx;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign dwell_eff = (dwell_cycles < CNT_W'(MIN_DWELL)) ? CNT_W'(MIN_DWELL) : dwell_cycles;
  assign busy      = (state == DWELL);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    load      = 1'b0;
    load_idx  = '0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          load      = 1'b1;
          load_idx  = arb_idx;
          state_nxt = DWELL;
        end
      end
      DWELL: begin
        if (cnt == CNT_W'(MIN_DWELL)) begin
          state_nxt = IDLE;
        end
`ifdef DISPLAY_SCHED_PREEMPT_EN
        // Preemption overrides the end-of-dwell exit and restarts the hold.
        if ((grant_idx != '0) && req_valid[0]) begin
          req_ready = NUM_REQ'(1);
          load      = 1'b1;
          load_idx  = '0;
          state_nxt = DWELL;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load_idx == IW'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_din  <= '0;
      disp_div  <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      disp_div <= cfg_div;
      if (load) begin
        disp_din  <= sel_data;
        grant_idx <= load_idx;
        ptr       <= (load_idx == IW'(NUM_REQ-1)) ? '0 : load_idx + 1'b1;
        cnt       <= dwell_eff;
      end else if (state == DWELL) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (default build, preemption disabled).
// Stimulus pushes the expected acceptance record; the monitor pops on each req_ready strobe.
// Latency: n/a. Backpressure: n/a.
module tb_display_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [31:0]  dwell_cycles;
  logic [31:0]  cfg_div;
  logic [31:0]  disp_din;
  logic [31:0]  disp_div;
  logic [1:0]   grant_idx;
  logic         busy;
  logic [31:0]  dat [4];

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  display_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .dwell_cycles (dwell_cycles),
    .cfg_div      (cfg_div),
    .disp_din     (disp_din),
    .disp_div     (disp_div),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  typedef struct {
    logic [3:0]  ready;
    logic [31:0] data;
    logic [1:0]  idx;
    int          len;   // expected DWELL length, 0 = not checked
    int          gap;   // expected cycles since previous accept, 0 = not checked
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   n        = 0;
  int   mstate   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic [31:0] d, input logic [1:0] i,
                      input int len, input int gap);
    exp_t e;
    e.ready = r; e.data = d; e.idx = i; e.len = len; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task handle_accept();
    if (sb.size() == 0) begin
      chk("unexpected_accept", 32'(req_ready), 32'h0);
    end else begin
      cur = sb.pop_front();
      chk("accept_ready", 32'(req_ready), 32'(cur.ready));
      if (cur.gap != 0) chk("accept_gap", 32'(cyc - last_acc), 32'(cur.gap));
      last_acc = cyc;
      mstate   = 1;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mstate = 0;
      end else begin
        case (mstate)
          0: if (req_ready != 4'b0) handle_accept();
          1: begin
            chk("disp_din", disp_din, cur.data);
            chk("grant_idx", 32'(grant_idx), 32'(cur.idx));
            chk("busy_after_accept", 32'(busy), 32'h1);
            chk("ready_low_in_dwell", 32'(req_ready), 32'h0);
            n      = 1;
            mstate = 2;
          end
          default: begin
            if (busy) begin
              n++;
              if (req_ready != 4'b0) chk("no_accept_in_dwell", 32'(req_ready), 32'h0);
            end else begin
              if (cur.len != 0) chk("dwell_len", 32'(n), 32'(cur.len));
              mstate = 0;
              if (req_ready != 4'b0) handle_accept();
            end
          end
        endcase
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 4'b0;
    dwell_cycles = 32'd0;
    cfg_div      = 32'd18;
    dat[0] = 32'hA0A0_0000;
    dat[1] = 32'hCAFE_0001;
    dat[2] = 32'h2222_2222;
    dat[3] = 32'h3333_3333;

    // Reset and quiet idle
    step(3);
    chk("rst_disp_din", disp_din, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_idx", 32'(grant_idx), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_disp_div", disp_div, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("disp_div_follow", disp_div, 32'd18);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_disp_din", disp_din, 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_req_ready", 32'(req_ready), 32'h0);
    end

    // Round-robin with all four pending, dwell 3: order 0,1,2,3,0 spaced 4 cycles
    step(1);
    dwell_cycles = 32'd3;
    push(4'b0001, 32'hA0A0_0000, 2'd0, 3, 0);
    push(4'b0010, 32'hCAFE_0001, 2'd1, 3, 4);
    push(4'b0100, 32'h2222_2222, 2'd2, 3, 4);
    push(4'b1000, 32'h3333_3333, 2'd3, 3, 4);
    push(4'b0001, 32'hA0A0_0000, 2'd0, 3, 4);
    req_valid = 4'b1111;
    step(17);
    req_valid = 4'b0;
    step(5);

    // Single request from requester 1, dwell 5; later data changes must not leak through
    dwell_cycles = 32'd5;
    push(4'b0010, 32'hCAFE_0001, 2'd1, 5, 0);
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0;
    dat[1]    = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    chk("data_sampled_once", disp_din, 32'hCAFE_0001);
    step(6);
    dat[1] = 32'hCAFE_0001;

    // Dwell of 0 is stretched to one cycle
    dwell_cycles = 32'd0;
    push(4'b0100, 32'h2222_2222, 2'd2, 1, 0);
    req_valid = 4'b0100;
    step(1);
    req_valid = 4'b0;
    step(3);

    // Dwell changed mid-hold; requester 0 waits for IDLE
    dwell_cycles = 32'd10;
    push(4'b1000, 32'h3333_3333, 2'd3, 10, 0);
    push(4'b0001, 32'hA0A0_0000, 2'd0, 2, 11);
    req_valid = 4'b1000;
    step(1);
    req_valid    = 4'b0;
    dwell_cycles = 32'd2;
    step(4);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("req0_waits", 32'(req_ready), 32'h0);
    step(7);
    req_valid = 4'b0;
    step(4);

    // Asynchronous reset in the third cycle of an 8-cycle hold
    dwell_cycles = 32'd8;
    push(4'b0010, 32'hCAFE_0001, 2'd1, 0, 0);
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0;
    step(2);
    #1;
    chk("busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_disp_din", disp_din, 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_grant_idx", 32'(grant_idx), 32'h0);
    chk("async_rst_req_ready", 32'(req_ready), 32'h0);
    step(2);
    rst_n        = 1'b1;
    dwell_cycles = 32'd4;
    push(4'b0100, 32'h2222_2222, 2'd2, 4, 0);
    req_valid = 4'b0100;
    step(1);
    req_valid = 4'b0;
    step(7);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
